// File: rtl/mac4_accum_sched.sv
// Job sequencer and accumulator for the 4-lane 8x8 multiply-add unit: issues one
// operand group per cycle, tracks in-flight groups by tag, and sums returned partials.
module mac4_accum_sched #(
   parameter int MAC_LAT = 2,
   parameter int ACC_W   = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_groups,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      mac_a,
   output logic [31:0]      mac_b,
   input  logic [31:0]      mac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_issued;
   logic [CNT_W-1:0]   r_returned;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [ACC_W-1:0]   r_outData;
   logic               r_outValid;
   logic [31:0]        r_macA;
   logic [31:0]        r_macB;
   logic [MAC_LAT-1:0] r_tag;

   logic               w_accept;
   logic               w_start;
   logic               w_ret;
   logic               w_lastIssue;
   logic               w_drainDone;
   logic [ACC_W-1:0]   w_ext;
   logic [ACC_W-1:0]   w_sum;
   logic               w_addOvf;

   assign in_ready    = (r_state == S_ISSUE) && (r_issued < r_len);
   assign w_accept    = in_valid && in_ready;
   assign w_start     = (r_state == S_IDLE) && start;
   assign w_ret       = r_tag[MAC_LAT-1];
   assign w_lastIssue = w_accept && ((r_issued + CNT_W'(1)) == r_len);
   assign w_drainDone = (r_state == S_DRAIN) && (r_returned == r_len);

   // Overflow: both addends share a sign that the wrapped sum does not.
   assign w_ext    = ACC_W'($signed(mac_result));
   assign w_sum    = r_acc + w_ext;
   assign w_addOvf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

   assign busy      = (r_state != S_IDLE);
   assign mac_a     = r_macA;
   assign mac_b     = r_macB;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_ovf   = r_ovf;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (cfg_groups == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (w_lastIssue) w_next = S_DRAIN;
         S_DRAIN: if (w_drainDone) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_len      <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_macA     <= '0;
         r_macB     <= '0;
         r_tag      <= '0;
      end else begin
         r_tag[0] <= w_accept;
         for (int k = 1; k < MAC_LAT; k++) r_tag[k] <= r_tag[k-1];

         if (w_accept) begin
            r_macA   <= in_a;
            r_macB   <= in_b;
            r_issued <= r_issued + CNT_W'(1);
         end

         // Returning partials share one add path whether still issuing or draining.
         if (w_start) begin
            r_len      <= cfg_groups;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_issued   <= '0;
            r_returned <= '0;
         end else if (w_ret) begin
            r_acc      <= w_sum;
            r_ovf      <= r_ovf | w_addOvf;
            r_returned <= r_returned + CNT_W'(1);
         end

         if (w_start && (cfg_groups == '0)) begin
            r_outData  <= '0;
            r_outValid <= 1'b1;
         end else if (w_drainDone) begin
            r_outData  <= r_acc;
            r_outValid <= 1'b1;
         end else if ((r_state == S_DONE) && out_ready) begin
            r_outValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac4_accum_sched.sv
// Directed bench for mac4_accum_sched: a behavioural multiply-add unit returns chosen
// partials, and a scoreboard of expected job results is checked at each output.
module tb_mac4_accum_sched;

   localparam int     LAT  = 2;
   localparam longint MAXV = 2147483647;
   localparam longint MINV = -MAXV - 1;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [15:0] cfg_groups;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] mac_a;
   logic [31:0] mac_b;
   logic [31:0] mac_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;

   int nCompared = 0;
   int nMismatch = 0;

   logic [31:0] jobA[$];
   logic [31:0] jobB[$];
   logic [31:0] jobR[$];
   logic [31:0] modelQ[$];
   logic [32:0] expQ[$];
   logic [31:0] stage [LAT];

   int edgeCnt     = 0;
   int readyCnt    = 0;
   int acceptCnt   = 0;
   int lastAccEdge = 0;
   int r0;
   int a0;

   mac4_accum_sched #(.MAC_LAT(LAT), .ACC_W(32), .CNT_W(16)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .cfg_groups (cfg_groups),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .mac_result (mac_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf)
   );

   always #5 clock = ~clock;

   // Behavioural unit: the partial for a group is presented LAT edges after its accept.
   assign mac_result = stage[LAT-1];

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < LAT; k++) stage[k] <= '0;
      end else begin
         if (in_valid && in_ready && (modelQ.size() > 0)) stage[0] <= modelQ.pop_front();
         else                                             stage[0] <= '0;
         for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
      end
   end

   always @(posedge clock) begin
      edgeCnt = edgeCnt + 1;
      if (in_ready) readyCnt = readyCnt + 1;
      if (in_valid && in_ready) begin
         acceptCnt   = acceptCnt + 1;
         lastAccEdge = edgeCnt;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pushes the job's expected sum/overflow and its partials, then pulses start.
   task automatic startJob(input logic [15:0] n);
      longint      s;
      logic [31:0] acc;
      logic        ovf;
      acc = '0;
      ovf = 1'b0;
      foreach (jobR[i]) begin
         s = longint'($signed(acc)) + longint'($signed(jobR[i]));
         if (s > MAXV || s < MINV) ovf = 1'b1;
         acc = s[31:0];
         modelQ.push_back(jobR[i]);
      end
      expQ.push_back({ovf, acc});
      start      = 1'b1;
      cfg_groups = n;
      @(negedge clock);
      start      = 1'b0;
   endtask

   task automatic applyStimulus(input int n, input logic [31:0] pat);
      int idx;
      int cyc;
      logic acc;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 64) begin
         in_valid = pat[cyc % 32];
         in_a     = jobA[idx];
         in_b     = jobB[idx];
         acc      = in_valid && in_ready;
         @(posedge clock);
         #1;
         if (acc) begin
            checkOutput("mac_a", mac_a, jobA[idx]);
            checkOutput("mac_b", mac_b, jobB[idx]);
            idx++;
         end
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0;
      if (idx < n) checkOutput("feed_timeout", idx, n);
   endtask

   task automatic waitResult(input int stall, input int expLat, input bit startAtHs);
      int w;
      logic [32:0] exp;
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clock);
         w++;
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 33'h0;
      if (!out_valid) begin
         checkOutput("out_valid_timeout", out_valid, 1);
         return;
      end
      if (expLat >= 0) checkOutput("latency", edgeCnt - lastAccEdge, expLat);
      checkOutput("out_data", out_data, exp[31:0]);
      checkOutput("out_ovf", out_ovf, exp[32]);
      for (int s = 0; s < stall; s++) begin
         @(negedge clock);
         checkOutput("held_valid", out_valid, 1);
         checkOutput("held_data", out_data, exp[31:0]);
      end
      out_ready = 1'b1;
      if (startAtHs) begin
         start      = 1'b1;
         cfg_groups = 16'd9;
      end
      @(negedge clock);
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("out_valid_drop", out_valid, 0);
      checkOutput("busy_drop", busy, 0);
   endtask

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      cfg_groups = '0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_ovf", out_ovf, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_mac_a", mac_a, 0);
      resetn = 1'b1;
      @(negedge clock);

      // Single group, latency of MAC_LAT+1 edges.
      jobA = '{32'h01010101};
      jobB = '{32'h02020202};
      jobR = '{32'd8};
      startJob(16'd1);
      checkOutput("busy_after_start", busy, 1);
      applyStimulus(1, 32'hFFFFFFFF);
      waitResult(0, LAT + 1, 1'b0);

      // Four back-to-back groups.
      jobA = '{32'h11223344, 32'h80FF7F01, 32'h00000005, 32'hA5A5A5A5};
      jobB = '{32'h01020304, 32'h7F80FF01, 32'hFFFFFFFF, 32'h5A5A5A5A};
      jobR = '{32'd10, -32'sd3, 32'd7, 32'd100};
      r0 = readyCnt;
      startJob(16'd4);
      applyStimulus(4, 32'hFFFFFFFF);
      waitResult(0, LAT + 1, 1'b0);
      checkOutput("ready_cycles_4", readyCnt - r0, 4);

      // Bubbles, a start while busy, a stalled output and a start on the handshake edge.
      jobA = '{32'h00000001, 32'h00000002, 32'h00000003};
      jobB = '{32'h10000000, 32'h20000000, 32'h30000000};
      jobR = '{32'd1000, 32'd2000, -32'sd500};
      r0 = readyCnt;
      a0 = acceptCnt;
      startJob(16'd3);
      start      = 1'b1;
      cfg_groups = 16'd1;
      @(negedge clock);
      start      = 1'b0;
      applyStimulus(3, 32'b10101);
      waitResult(5, LAT + 1, 1'b1);
      checkOutput("ready_cycles_3", readyCnt - r0, 6);
      checkOutput("accepts_3", acceptCnt - a0, 3);

      // Empty job goes straight to DONE without offering in_ready.
      jobR.delete();
      r0 = readyCnt;
      startJob(16'd0);
      start      = 1'b1;
      cfg_groups = 16'd3;
      @(negedge clock);
      start      = 1'b0;
      checkOutput("empty_busy", busy, 1);
      waitResult(0, -1, 1'b0);
      checkOutput("empty_no_ready", readyCnt - r0, 0);

      // Signed overflow wraps and is sticky, then cleared by the next job.
      jobA = '{32'h7F7F7F7F, 32'h7F7F7F7F};
      jobB = '{32'h7F7F7F7F, 32'h7F7F7F7F};
      jobR = '{32'h7FFFFFFF, 32'h7FFFFFFF};
      startJob(16'd2);
      applyStimulus(2, 32'hFFFFFFFF);
      waitResult(0, LAT + 1, 1'b0);
      jobA = '{32'h00000005};
      jobB = '{32'h00000001};
      jobR = '{32'd5};
      startJob(16'd1);
      checkOutput("ovf_cleared", out_ovf, 0);
      applyStimulus(1, 32'hFFFFFFFF);
      waitResult(0, LAT + 1, 1'b0);

      // Reset while two results are in flight; the next job must see none of them.
      jobA = '{32'h01010101, 32'h02020202};
      jobB = '{32'h01010101, 32'h02020202};
      jobR = '{32'd50, 32'd60};
      startJob(16'd2);
      applyStimulus(2, 32'hFFFFFFFF);
      resetn = 1'b0;
      modelQ.delete();
      expQ.delete();
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_mac_b", mac_b, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      jobA = '{32'h00000003};
      jobB = '{32'h00000002};
      jobR = '{32'd6};
      startJob(16'd1);
      applyStimulus(1, 32'hFFFFFFFF);
      waitResult(0, LAT + 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
